// File: rtl/interrupt_request_resolver.sv
// 8259A interrupt request register and priority resolver with a registered one-hot winner.
// Optional: define SPECIAL_MASK_MODE_EN to add the special_mask_mode input (OCW3 SMM).
module interrupt_request_resolver #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    input  logic               level_or_edge_triggered,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic [NUM_IRQ-1:0] in_service_register,
    input  logic [2:0]         priority_rotate,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
`ifdef SPECIAL_MASK_MODE_EN
    input  logic               special_mask_mode,
`endif
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic [NUM_IRQ-1:0] interrupt,
    output logic               interrupt_pending
);

    localparam int unsigned LP_N = NUM_IRQ;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_irr;
    logic [NUM_IRQ-1:0] r_interrupt;
    logic               r_pending;

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_irr_next;
    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_isr_eff;
    logic [NUM_IRQ-1:0] w_winner;
    logic               w_found;
    logic               w_blocked;
    logic [2:0]         w_idx;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_req  = r_irr & ~interrupt_mask;

`ifdef SPECIAL_MASK_MODE_EN
    assign w_isr_eff = special_mask_mode ? (in_service_register & ~interrupt_mask)
                                         : in_service_register;
`else
    assign w_isr_eff = in_service_register;
`endif

    // Clear beats freeze beats set; a dropped or frozen set is not remembered.
    always_comb begin
        w_irr_next = r_irr;
        if (freeze) begin
            w_irr_next = r_irr;
        end else if (level_or_edge_triggered) begin
            w_irr_next = w_sync;
        end else begin
            w_irr_next = r_irr | (w_sync & ~r_prev);
        end
        w_irr_next = w_irr_next & ~clear_interrupt_request;
    end

    // Walk levels from highest priority down; the first in-service level met (including one
    // equal to the candidate) blocks everything from there on.
    always_comb begin
        w_winner  = '0;
        w_found   = 1'b0;
        w_blocked = 1'b0;
        w_idx     = '0;
        for (int unsigned j = 0; j < LP_N; j++) begin
            w_idx = priority_rotate + 3'd1 + 3'(j);
            if (!w_found && !w_blocked) begin
                if (w_isr_eff[w_idx]) begin
                    w_blocked = 1'b1;
                end else if (w_req[w_idx]) begin
                    w_winner[w_idx] = 1'b1;
                    w_found         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '0;
            r_prev      <= '0;
            r_irr       <= '0;
            r_interrupt <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_sync[0] <= interrupt_request_pin;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_sync;
            r_irr  <= w_irr_next;
            if (!freeze) begin
                r_interrupt <= w_winner;
                r_pending   <= w_found;
            end
        end
    end

    assign interrupt_request_register = r_irr;
    assign interrupt                  = r_interrupt;
    assign interrupt_pending          = r_pending;

endmodule

// File: tb/tb_interrupt_request_resolver.sv
// Scoreboard bench for interrupt_request_resolver: expectations queued with a due cycle at drive time.
module tb_interrupt_request_resolver;

    logic       clock;
    logic       reset_n;
    logic [7:0] interrupt_request_pin;
    logic       level_or_edge_triggered;
    logic [7:0] interrupt_mask;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
`ifdef SPECIAL_MASK_MODE_EN
    logic       special_mask_mode;
`endif
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt;
    logic       interrupt_pending;

    interrupt_request_resolver #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .interrupt_request_pin      (interrupt_request_pin),
        .level_or_edge_triggered    (level_or_edge_triggered),
        .interrupt_mask             (interrupt_mask),
        .in_service_register        (in_service_register),
        .priority_rotate            (priority_rotate),
        .freeze                     (freeze),
        .clear_interrupt_request    (clear_interrupt_request),
`ifdef SPECIAL_MASK_MODE_EN
        .special_mask_mode          (special_mask_mode),
`endif
        .interrupt_request_register (interrupt_request_register),
        .interrupt                  (interrupt),
        .interrupt_pending          (interrupt_pending)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         sb_due[$];
    logic [7:0] sb_irr[$];
    logic [7:0] sb_int[$];
    logic       sb_pend[$];
    string      sb_tag[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int dly, input logic [7:0] irr,
                             input logic [7:0] intr, input logic pend);
        sb_due.push_back(cyc + dly);
        sb_irr.push_back(irr);
        sb_int.push_back(intr);
        sb_pend.push_back(pend);
        sb_tag.push_back(tag);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        while (sb_due.size() > 0 && sb_due[0] <= cyc) begin
            int         d;
            logic [7:0] e_irr;
            logic [7:0] e_int;
            logic       e_pend;
            string      t;
            d      = sb_due.pop_front();
            e_irr  = sb_irr.pop_front();
            e_int  = sb_int.pop_front();
            e_pend = sb_pend.pop_front();
            t      = sb_tag.pop_front();
            check_val({t, "_due"}, 8'(cyc - d), 8'd0);
            check_val({t, "_irr"}, interrupt_request_register, e_irr);
            check_val({t, "_int"}, interrupt, e_int);
            check_val({t, "_pend"}, {7'd0, interrupt_pending}, {7'd0, e_pend});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n                 = 1'b0;
        interrupt_request_pin   = '0;
        level_or_edge_triggered = 1'b0;
        interrupt_mask          = '0;
        in_service_register     = '0;
        priority_rotate         = 3'd7;
        freeze                  = 1'b0;
        clear_interrupt_request = '0;
`ifdef SPECIAL_MASK_MODE_EN
        special_mask_mode       = 1'b0;
`endif
        tick(2);
        check_val("rst_irr", interrupt_request_register, 8'h00);
        check_val("rst_int", interrupt, 8'h00);
        check_val("rst_pend", {7'd0, interrupt_pending}, 8'h00);
        reset_n = 1'b1;
        tick(2);

        // Edge mode single pulse on IR3, then acknowledge
        interrupt_request_pin = 8'h08;
        expect_at("t1_irr_set", 3, 8'h08, 8'h00, 1'b0);
        expect_at("t1_win", 4, 8'h08, 8'h08, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
        clear_interrupt_request = 8'h08;
        expect_at("t1_clr", 1, 8'h00, 8'h08, 1'b1);
        expect_at("t1_idle", 2, 8'h00, 8'h00, 1'b0);
        tick(1);
        clear_interrupt_request = 8'h00;
        tick(1);

        // Rotation: IR2 wins at rotate=7, IR5 at rotate=3; multi-bit clear
        interrupt_request_pin = 8'h24;
        expect_at("t2_rot7", 4, 8'h24, 8'h04, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
        priority_rotate = 3'd3;
        expect_at("t2_rot3", 1, 8'h24, 8'h20, 1'b1);
        tick(1);
        clear_interrupt_request = 8'h24;
        priority_rotate = 3'd7;
        expect_at("t2_clr", 1, 8'h00, 8'h04, 1'b1);
        expect_at("t2_idle", 2, 8'h00, 8'h00, 1'b0);
        tick(1);
        clear_interrupt_request = 8'h00;
        tick(1);

        // Fully nested: IR2 in service
        in_service_register   = 8'h04;
        interrupt_request_pin = 8'h22;
        expect_at("t3_ir1", 4, 8'h22, 8'h02, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
        clear_interrupt_request = 8'h02;
        expect_at("t3_clr1", 1, 8'h20, 8'h02, 1'b1);
        expect_at("t3_blk", 2, 8'h20, 8'h00, 1'b0);
        tick(1);
        clear_interrupt_request = 8'h00;
        tick(1);
        in_service_register = 8'h00;
        expect_at("t3_unblk", 1, 8'h20, 8'h20, 1'b1);
        tick(1);

        // Freeze: an IR0 edge during freeze is lost
        clear_interrupt_request = 8'h20;
        expect_at("t4_clr5", 1, 8'h00, 8'h20, 1'b1);
        tick(1);
        clear_interrupt_request = 8'h00;
        interrupt_request_pin = 8'h02;
        expect_at("t4_irr", 3, 8'h02, 8'h00, 1'b0);
        expect_at("t4_win", 4, 8'h02, 8'h02, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
        freeze = 1'b1;
        interrupt_request_pin = 8'h01;
        expect_at("t4_frz_a", 3, 8'h02, 8'h02, 1'b1);
        expect_at("t4_frz_b", 4, 8'h02, 8'h02, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(4);
        freeze = 1'b0;
        expect_at("t4_lost", 2, 8'h02, 8'h02, 1'b1);
        tick(2);
        clear_interrupt_request = 8'h02;
        expect_at("t4_clr", 1, 8'h00, 8'h02, 1'b1);
        expect_at("t4_idle", 2, 8'h00, 8'h00, 1'b0);
        tick(1);
        clear_interrupt_request = 8'h00;
        tick(1);

        // Level mode: IRR follows the pin
        level_or_edge_triggered = 1'b1;
        interrupt_request_pin = 8'h40;
        expect_at("t5_lvl_set", 3, 8'h40, 8'h00, 1'b0);
        expect_at("t5_lvl_win", 4, 8'h40, 8'h40, 1'b1);
        tick(4);
        interrupt_request_pin = 8'h00;
        expect_at("t5_lvl_drop", 3, 8'h00, 8'h40, 1'b1);
        expect_at("t5_lvl_idle", 4, 8'h00, 8'h00, 1'b0);
        tick(4);
        interrupt_request_pin = 8'h40;
        expect_at("t5_lvl_again", 4, 8'h40, 8'h40, 1'b1);
        tick(4);
        #5;
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_irr", interrupt_request_register, 8'h00);
        check_val("t5_rst_int", interrupt, 8'h00);
        check_val("t5_rst_pend", {7'd0, interrupt_pending}, 8'h00);
        interrupt_request_pin = 8'h00;
        level_or_edge_triggered = 1'b0;
        tick(2);
        reset_n = 1'b1;
        expect_at("t5_post_rst", 2, 8'h00, 8'h00, 1'b0);
        tick(2);

        // Masked in-service IR0 with IR4 pending; mask itself gates the request
        in_service_register = 8'h01;
        interrupt_mask      = 8'h01;
`ifdef SPECIAL_MASK_MODE_EN
        special_mask_mode = 1'b1;
        interrupt_request_pin = 8'h10;
        expect_at("t6_smm_on", 4, 8'h10, 8'h10, 1'b1);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
        special_mask_mode = 1'b0;
        expect_at("t6_smm_off", 1, 8'h10, 8'h00, 1'b0);
        tick(1);
`else
        interrupt_request_pin = 8'h10;
        expect_at("t6_nested", 4, 8'h10, 8'h00, 1'b0);
        tick(1);
        interrupt_request_pin = 8'h00;
        tick(3);
`endif
        in_service_register = 8'h00;
        interrupt_mask      = 8'h10;
        expect_at("t6_masked", 1, 8'h10, 8'h00, 1'b0);
        tick(1);
        interrupt_mask = 8'h00;
        expect_at("t6_unmask", 1, 8'h10, 8'h10, 1'b1);
        tick(1);
        clear_interrupt_request = 8'h10;
        expect_at("t6_clr", 1, 8'h00, 8'h10, 1'b1);
        expect_at("t6_idle", 2, 8'h00, 8'h00, 1'b0);
        tick(1);
        clear_interrupt_request = 8'h00;
        tick(1);

        for (int i = 0; i < 20 && sb_due.size() > 0; i++) tick(1);
        check_val("sb_drain", 8'(sb_due.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
